bp_load_align_pipe: RTL and testbench

Load-return alignment stage between the memory response bus and the core writeback path. It records per-load metadata (byte offset, access size, signedness) when a load issues. It pairs each in-order memory response with the oldest metadata entry, then rotates, truncates and sign/zero-extends the response word. The result goes through one registered, ready/valid output stage.

---
 rtl/bp_load_align_pkg.sv | 13 +
 rtl/bp_load_align_pipe_if.sv | 32 +++
 rtl/bp_load_align_meta_fifo.sv | 49 ++++
 rtl/bp_load_align_pipe.sv | 62 ++++++
 tb/tb_bp_load_align_pipe.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/bp_load_align_pkg.sv
// bp_load_align_pkg: size encodings, width helper and metadata struct macro shared by the load-align slice
`define BP_LOAD_ALIGN_META_S(sel_w) struct packed { logic sgn; logic [bp_load_align_pkg::size_width(sel_w)-1:0] size; logic [(sel_w)-1:0] sel; }

package bp_load_align_pkg;
   localparam int size_byte   = 0;
   localparam int size_half   = 1;
   localparam int size_word   = 2;
   localparam int size_double = 3;

   function automatic int size_width(input int sel_w);
      return (sel_w < 1) ? 1 : $clog2(sel_w + 1);
   endfunction
endpackage

// File: rtl/bp_load_align_pipe_if.sv
// bp_load_align_pipe_if: load metadata, memory response and aligned result channels
interface bp_load_align_pipe_if
   import bp_load_align_pkg::*;
   #(parameter int data_width_p = 64,
     parameter int unit_width_p = 8,
     parameter int els_p        = 4) ();
   localparam int sel_width_lp  = $clog2(data_width_p / unit_width_p);
   localparam int size_width_lp = size_width(sel_width_lp);
   localparam int cnt_width_lp  = $clog2(els_p + 1);
   logic                     req_v_i;
   logic                     req_ready_o;
   logic [sel_width_lp-1:0]  req_sel_i;
   logic [size_width_lp-1:0] req_size_i;
   logic                     req_signed_i;
   logic                     resp_v_i;
   logic                     resp_ready_o;
   logic [data_width_p-1:0]  resp_data_i;
   logic                     data_v_o;
   logic                     data_ready_i;
   logic [data_width_p-1:0]  data_o;
   logic [cnt_width_lp-1:0]  pending_o;

   modport master (
      output req_v_i, req_sel_i, req_size_i, req_signed_i, resp_v_i, resp_data_i, data_ready_i,
      input  req_ready_o, resp_ready_o, data_v_o, data_o, pending_o
   );

   modport slave (
      input  req_v_i, req_sel_i, req_size_i, req_signed_i, resp_v_i, resp_data_i, data_ready_i,
      output req_ready_o, resp_ready_o, data_v_o, data_o, pending_o
   );
endinterface

// File: rtl/bp_load_align_meta_fifo.sv
// bp_load_align_meta_fifo: 1r1w metadata FIFO with count output and no bypass in either direction
module bp_load_align_meta_fifo #(
   parameter int width_p = 6,
   parameter int els_p   = 4,
   localparam int cnt_width_lp = $clog2(els_p + 1)
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    v_i,
   input  logic [width_p-1:0]      data_i,
   output logic                    ready_o,
   input  logic                    yumi_i,
   output logic [width_p-1:0]      data_o,
   output logic [cnt_width_lp-1:0] count_o
);
   localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
   logic [width_p-1:0]      mem_q [els_p];
   logic [width_p-1:0]      mem_d [els_p];
   logic [ptr_width_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [cnt_width_lp-1:0] count_q, count_d;
   logic                    push, pop;

   always_comb begin
      ready_o = count_q != cnt_width_lp'(els_p);
      push    = v_i & ready_o;
      pop     = yumi_i & (count_q != '0);
      mem_d   = mem_q;
      if (push) mem_d[wptr_q] = data_i;
      wptr_d  = push ? ((wptr_q == ptr_width_lp'(els_p - 1)) ? '0 : wptr_q + ptr_width_lp'(1)) : wptr_q;
      rptr_d  = pop ? ((rptr_q == ptr_width_lp'(els_p - 1)) ? '0 : rptr_q + ptr_width_lp'(1)) : rptr_q;
      count_d = count_q + cnt_width_lp'(push) - cnt_width_lp'(pop);
      data_o  = mem_q[rptr_q];
      count_o = count_q;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         mem_q   <= '{default: '0};
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/bp_load_align_pipe.sv
// bp_load_align_pipe: pairs in-order load responses with queued metadata, aligns/extends them, registers the result
module bp_load_align_pipe
   import bp_load_align_pkg::*;
   #(parameter int data_width_p = 64,
     parameter int unit_width_p = 8,
     parameter int els_p        = 4)
   (input logic clk_i,
    input logic reset_n_i,
    bp_load_align_pipe_if.slave io);
   localparam int sel_width_lp   = $clog2(data_width_p / unit_width_p);
   localparam int size_width_lp  = size_width(sel_width_lp);
   localparam int cnt_width_lp   = $clog2(els_p + 1);
   localparam int shift_width_lp = $clog2(data_width_p) + 1;
   typedef `BP_LOAD_ALIGN_META_S(sel_width_lp) meta_s;
   meta_s                     req_meta, resp_meta;
   logic [cnt_width_lp-1:0]   count;
   logic                      pop, data_v_q, data_v_d;
   logic [data_width_p-1:0]   data_q, data_d, rot, mask, sign_sh, ext;
   logic [2*data_width_p-1:0] dbl;
   logic [shift_width_lp-1:0] shamt, w;

   assign req_meta = '{sgn: io.req_signed_i, size: io.req_size_i, sel: io.req_sel_i};

   bp_load_align_meta_fifo #(.width_p($bits(meta_s)), .els_p(els_p)) meta_fifo (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .v_i      (io.req_v_i),
      .data_i   (req_meta),
      .ready_o  (io.req_ready_o),
      .yumi_i   (pop),
      .data_o   (resp_meta),
      .count_o  (count)
   );

   always_comb begin
      io.resp_ready_o = (count != '0) & (~data_v_q | io.data_ready_i);
      pop             = io.resp_v_i & io.resp_ready_o;
      shamt           = shift_width_lp'(resp_meta.sel) << $clog2(unit_width_p);
      dbl             = {io.resp_data_i, io.resp_data_i} >> shamt;
      rot             = dbl[data_width_p-1:0];
      w               = shift_width_lp'(unit_width_p) << resp_meta.size;
      mask            = ~({data_width_p{1'b1}} << w);
      sign_sh         = rot >> (w - shift_width_lp'(1));
      ext             = (resp_meta.size >= size_width_lp'(sel_width_lp)) ? rot
                        : (rot & mask) | ({data_width_p{resp_meta.sgn & sign_sh[0]}} & ~mask);
      data_v_d        = pop | (data_v_q & ~io.data_ready_i);
      data_d          = pop ? ext : data_q;
      io.data_v_o     = data_v_q;
      io.data_o       = data_q;
      io.pending_o    = count;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         data_v_q <= 1'b0;
         data_q   <= '0;
      end else begin
         data_v_q <= data_v_d;
         data_q   <= data_d;
      end
   end
endmodule

// File: tb/tb_bp_load_align_pipe.sv
// tb_bp_load_align_pipe: directed and randomized checks of the load-align pipe against a queue-based model
module tb_bp_load_align_pipe;
   import bp_load_align_pkg::*;
   typedef struct {int sel; int size; bit sgn;} m_t;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int vectors = 0;
   int errors = 0;
   m_t q[$];
   bit mv = 1'b0;
   logic [63:0] md = '0;

   bp_load_align_pipe_if #(.data_width_p(64), .unit_width_p(8), .els_p(4)) io ();
   bp_load_align_pipe #(.data_width_p(64), .unit_width_p(8), .els_p(4)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .io(io.slave));

   always #5 clk = ~clk;

   function automatic logic [63:0] align_ref(int sel, int size, bit sgn, logic [63:0] d);
      logic [63:0] r;
      int w;
      for (int i = 0; i < 64; i++) r[i] = d[(i + sel * 8) % 64];
      if (size >= 3) return r;
      w = 8 << size;
      for (int i = w; i < 64; i++) r[i] = sgn ? r[w-1] : 1'b0;
      return r;
   endfunction

   task automatic model_reset();
      q.delete();
      mv = 1'b0;
      md = '0;
   endtask

   task automatic tick();
      bit push_ok, pop_ok;
      m_t m;
      @(negedge clk);
      push_ok = io.req_v_i && q.size() != 4;
      pop_ok = io.resp_v_i && q.size() != 0 && (!mv || io.data_ready_i);
      if (pop_ok) begin
         m = q.pop_front();
         md = align_ref(m.sel, m.size, m.sgn, io.resp_data_i);
         mv = 1'b1;
      end else if (io.data_ready_i) mv = 1'b0;
      if (push_ok) begin
         m.sel = int'(io.req_sel_i); m.size = int'(io.req_size_i); m.sgn = io.req_signed_i;
         q.push_back(m);
      end
      @(posedge clk); #1;
   endtask

   task automatic set_req(input bit v, input int sel, input int size, input bit sgn);
      io.req_v_i = v; io.req_sel_i = 3'(sel); io.req_size_i = 2'(size); io.req_signed_i = sgn;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #1;
      vectors++; if (io.req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", io.req_ready_o); end
      vectors++; if (io.resp_ready_o !== 1'b0) begin errors++; $display("FAIL reset_resp_ready got %b want 0", io.resp_ready_o); end
      vectors++; if (io.data_v_o !== 1'b0) begin errors++; $display("FAIL reset_data_v got %b want 0", io.data_v_o); end
      vectors++; if (io.data_o !== 64'h0) begin errors++; $display("FAIL reset_data got %h want 0", io.data_o); end
      vectors++; if (io.pending_o !== 3'd0) begin errors++; $display("FAIL reset_pending got %0d want 0", io.pending_o); end
      model_reset();
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   task automatic test_directed();
      int sel[3] = '{3, 2, 7};
      int size[3] = '{size_byte, size_half, size_half};
      bit sgn[3] = '{1'b1, 1'b0, 1'b0};
      logic [63:0] word[3] = '{64'h00000000_80000000, 64'h00000000_ABCD0000, 64'h12000000_00000034};
      logic [63:0] expv[3] = '{64'hFFFFFFFF_FFFFFF80, 64'h00000000_0000ABCD, 64'h00000000_00003412};
      io.data_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_req(1'b1, sel[i], size[i], sgn[i]);
         tick();
         set_req(1'b0, 0, 0, 1'b0);
         io.resp_v_i = 1'b1; io.resp_data_i = word[i];
         #1;
         vectors++; if (io.resp_ready_o !== 1'b1) begin errors++; $display("FAIL directed%0d_resp_ready got %b want 1", i, io.resp_ready_o); end
         tick();
         io.resp_v_i = 1'b0;
         vectors++; if (io.data_v_o !== 1'b1 || io.data_o !== expv[i])
            begin errors++; $display("FAIL directed%0d_data got v=%b %h want v=1 %h", i, io.data_v_o, io.data_o, expv[i]); end
         tick();
         vectors++; if (io.data_v_o !== 1'b0) begin errors++; $display("FAIL directed%0d_clear got %b want 0", i, io.data_v_o); end
      end
   endtask

   task automatic test_full();
      io.data_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_req(1'b1, $urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom));
         tick();
      end
      #1;
      vectors++; if (io.req_ready_o !== 1'b0) begin errors++; $display("FAIL full_req_ready got %b want 0", io.req_ready_o); end
      vectors++; if (io.pending_o !== 3'd4) begin errors++; $display("FAIL full_pending got %0d want 4", io.pending_o); end
      io.resp_v_i = 1'b1; io.resp_data_i = {$urandom, $urandom};
      tick();
      set_req(1'b0, 0, 0, 1'b0);
      vectors++; if (io.pending_o !== 3'd3) begin errors++; $display("FAIL full_push_reject got %0d want 3", io.pending_o); end
      vectors++; if (io.data_o !== md) begin errors++; $display("FAIL full_pop0 got %h want %h", io.data_o, md); end
      for (int i = 1; i < 4; i++) begin
         io.resp_data_i = {$urandom, $urandom};
         tick();
         vectors++; if (io.data_v_o !== 1'b1 || io.data_o !== md)
            begin errors++; $display("FAIL full_drain%0d got v=%b %h want %h", i, io.data_v_o, io.data_o, md); end
      end
      io.resp_v_i = 1'b0;
      tick();
      vectors++; if (io.pending_o !== 3'd0) begin errors++; $display("FAIL full_empty got %0d want 0", io.pending_o); end
   endtask

   task automatic test_backpressure();
      logic [63:0] first;
      io.data_ready_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         set_req(1'b1, $urandom_range(0, 7), $urandom_range(0, 3), 1'b1);
         tick();
      end
      set_req(1'b0, 0, 0, 1'b0);
      io.data_ready_i = 1'b0;
      io.resp_v_i = 1'b1; io.resp_data_i = 64'h8899AABB_CCDDEEFF;
      tick();
      first = md;
      io.resp_data_i = 64'hF0E1D2C3_B4A59687;
      for (int i = 0; i < 2; i++) begin
         vectors++; if (io.resp_ready_o !== 1'b0) begin errors++; $display("FAIL bp_resp_ready%0d got %b want 0", i, io.resp_ready_o); end
         tick();
         vectors++; if (io.data_v_o !== 1'b1 || io.data_o !== first)
            begin errors++; $display("FAIL bp_hold%0d got v=%b %h want %h", i, io.data_v_o, io.data_o, first); end
      end
      io.data_ready_i = 1'b1;
      #1;
      vectors++; if (io.resp_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", io.resp_ready_o); end
      tick();
      io.resp_v_i = 1'b0;
      vectors++; if (io.data_v_o !== 1'b1 || io.data_o !== md)
         begin errors++; $display("FAIL bp_second got v=%b %h want %h", io.data_v_o, io.data_o, md); end
      tick();
   endtask

   task automatic test_reset_mid();
      io.data_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_req(1'b1, i, 0, 1'b0);
         tick();
      end
      set_req(1'b0, 0, 0, 1'b0);
      io.resp_v_i = 1'b1; io.resp_data_i = 64'h01234567_89ABCDEF;
      tick();
      io.resp_v_i = 1'b0;
      vectors++; if (io.pending_o !== 3'd2 || io.data_v_o !== 1'b1)
         begin errors++; $display("FAIL mid_setup got pend=%0d v=%b want 2 1", io.pending_o, io.data_v_o); end
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      vectors++; if (io.req_ready_o !== 1'b1 || io.resp_ready_o !== 1'b0 || io.data_v_o !== 1'b0 || io.data_o !== 64'h0 || io.pending_o !== 3'd0)
         begin errors++; $display("FAIL mid_async got rr=%b rs=%b v=%b d=%h p=%0d want 1 0 0 0 0", io.req_ready_o, io.resp_ready_o, io.data_v_o, io.data_o, io.pending_o); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      io.data_ready_i = 1'b1;
      io.resp_v_i = 1'b1; io.resp_data_i = 64'hFEDCBA98_76543210;
      #1;
      vectors++; if (io.resp_ready_o !== 1'b0) begin errors++; $display("FAIL mid_noaccept got %b want 0", io.resp_ready_o); end
      tick();
      vectors++; if (io.data_v_o !== 1'b0) begin errors++; $display("FAIL mid_nodata got %b want 0", io.data_v_o); end
      set_req(1'b1, 4, size_word, 1'b1);
      #1;
      vectors++; if (io.resp_ready_o !== 1'b0) begin errors++; $display("FAIL mid_nobypass got %b want 0", io.resp_ready_o); end
      tick();
      set_req(1'b0, 0, 0, 1'b0);
      vectors++; if (io.data_v_o !== 1'b0 || io.pending_o !== 3'd1)
         begin errors++; $display("FAIL mid_push got v=%b p=%0d want 0 1", io.data_v_o, io.pending_o); end
      tick();
      io.resp_v_i = 1'b0;
      vectors++; if (io.data_v_o !== 1'b1 || io.data_o !== 64'hFFFFFFFF_FEDCBA98)
         begin errors++; $display("FAIL mid_after got v=%b %h want 1 fffffffffedcba98", io.data_v_o, io.data_o); end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         set_req(1'($urandom), $urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom));
         io.resp_v_i = 1'($urandom);
         io.resp_data_i = {$urandom, $urandom};
         io.data_ready_i = $urandom_range(0, 3) != 0;
         #1;
         vectors++; if (io.req_ready_o !== (q.size() != 4))
            begin errors++; $display("FAIL rnd%0d_req_ready got %b want %b", i, io.req_ready_o, q.size() != 4); end
         vectors++; if (io.resp_ready_o !== (q.size() != 0 && (!mv || io.data_ready_i)))
            begin errors++; $display("FAIL rnd%0d_resp_ready got %b", i, io.resp_ready_o); end
         tick();
         vectors++; if (io.data_v_o !== mv) begin errors++; $display("FAIL rnd%0d_data_v got %b want %b", i, io.data_v_o, mv); end
         if (mv) begin
            vectors++; if (io.data_o !== md) begin errors++; $display("FAIL rnd%0d_data got %h want %h", i, io.data_o, md); end
         end
         vectors++; if (io.pending_o !== 3'(q.size()))
            begin errors++; $display("FAIL rnd%0d_pending got %0d want %0d", i, io.pending_o, q.size()); end
      end
      set_req(1'b0, 0, 0, 1'b0);
      io.resp_v_i = 1'b0;
      io.data_ready_i = 1'b1;
   endtask

   initial begin
      set_req(1'b0, 0, 0, 1'b0);
      io.resp_v_i = 1'b0;
      io.resp_data_i = '0;
      io.data_ready_i = 1'b1;
      #2;
      test_reset();
      test_directed();
      test_full();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
